// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, step kinds,
// and the binary-to-Gray conversion used by both the design and its bench.
package gray_pkg;

  localparam int GRAY_SIZE_DEFAULT = 8;

  // What the counter does on a given edge, after priority has been resolved.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  // Operates on a full 32-bit word; callers narrower than 32 bits keep the
  // low bits, which is exact because the upper input bits are zero.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray-code counter: count/load controls in,
// registered binary, Gray and wrap status out.
interface gray_counter_if #(
  parameter int SIZE = gray_pkg::GRAY_SIZE_DEFAULT
);

  logic            en;
  logic            up;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] bin;
  logic [SIZE-1:0] gray;
  logic            wrap;

  modport master (
    output en, up, load, load_val,
    input  bin, gray, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output bin, gray, wrap
  );

endinterface

// File: rtl/gray_counter_bin2gray.sv
// Purely combinational binary-to-Gray converter: each Gray bit is the XOR of
// a binary bit with its next-higher neighbour.
module bin2gray
  import gray_pkg::*;
#(
  parameter int SIZE = GRAY_SIZE_DEFAULT
) (
  input  logic [SIZE-1:0] bin_i,
  output logic [SIZE-1:0] gray_o
);

  assign gray_o = SIZE'(bin_to_gray(32'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy and a wrap pulse.
// The Gray register is fed from the next binary value, so it never lags bin.
module gray_counter
  import gray_pkg::*;
#(
  parameter int SIZE = GRAY_SIZE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_counter_if.slave bus
);

  logic [SIZE-1:0] bin_q;
  logic [SIZE-1:0] gray_q;
  logic            wrap_q;

  logic [SIZE-1:0] bin_nxt;
  logic [SIZE-1:0] gray_nxt;
  logic            wrap_nxt;
  step_e           step;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    step     = STEP_HOLD;
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;

    if (bus.load) begin
      step = STEP_LOAD;
    end else if (bus.en) begin
      step = bus.up ? STEP_UP : STEP_DOWN;
    end

    // Wrap is judged on the value being left, not the value being entered.
    case (step)
      STEP_LOAD: bin_nxt = bus.load_val;
      STEP_UP: begin
        bin_nxt  = bin_q + SIZE'(1);
        wrap_nxt = &bin_q;
      end
      STEP_DOWN: begin
        bin_nxt  = bin_q - SIZE'(1);
        wrap_nxt = ~|bin_q;
      end
      default: ;
    endcase
  end

  bin2gray #(
    .SIZE (SIZE)
  ) u_bin2gray (
    .bin_i  (bin_nxt),
    .gray_o (gray_nxt)
  );

  // NOTE: reset is sampled on the clock edge only; there is no asynchronous
  // path, and reset wins over load and enable on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomized checks of gray_counter at widths 5 and 8 against an
// arithmetic reference model of the count, Gray code and wrap pulse.
module tb_gray_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   m5 = 0;
  int   m8 = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.SIZE(5)) bus5 ();
  gray_counter_if #(.SIZE(8)) bus8 ();

  gray_counter #(.SIZE(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
  gray_counter #(.SIZE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour expressed with plain modular arithmetic.
  function automatic void model(input int w, input int cur, input bit rst, input bit ld,
                                input bit en, input bit up, input int lv,
                                output int nxt, output bit wr);
    int m;
    m   = 1 << w;
    nxt = cur;
    wr  = 1'b0;
    if (rst) begin
      nxt = 0;
    end else if (ld) begin
      nxt = lv % m;
    end else if (en) begin
      if (up) begin
        nxt = (cur + 1) % m;
        wr  = (cur == m - 1);
      end else begin
        nxt = (cur + m - 1) % m;
        wr  = (cur == 0);
      end
    end
  endfunction

  function automatic int gray_of(input int v);
    return v ^ (v / 2);
  endfunction

  task automatic cycle(input string tag);
    int          n5, n8;
    bit          w5, w8;
    bit          st5, st8;
    logic [31:0] pg5, pg8;
    pg5 = 32'(bus5.gray);
    pg8 = 32'(bus8.gray);
    st5 = rst_n && !bus5.load && bus5.en;
    st8 = rst_n && !bus8.load && bus8.en;
    model(5, m5, !rst_n, bus5.load, bus5.en, bus5.up, int'(bus5.load_val), n5, w5);
    model(8, m8, !rst_n, bus8.load, bus8.en, bus8.up, int'(bus8.load_val), n8, w8);
    @(posedge clk);
    #1;
    m5 = n5;
    m8 = n8;
    check({tag, "/bin5"},  32'(bus5.bin),  32'(m5));
    check({tag, "/gray5"}, 32'(bus5.gray), 32'(gray_of(m5)));
    check({tag, "/wrap5"}, 32'(bus5.wrap), 32'(w5));
    check({tag, "/bin8"},  32'(bus8.bin),  32'(m8));
    check({tag, "/gray8"}, 32'(bus8.gray), 32'(gray_of(m8)));
    check({tag, "/wrap8"}, 32'(bus8.wrap), 32'(w8));
    check({tag, "/pkgfn5"}, 32'(bus5.gray), bin_to_gray(32'(bus5.bin)));
    if (st5) check({tag, "/ham5"}, 32'($countones(32'(bus5.gray) ^ pg5)), 32'd1);
    if (st8) check({tag, "/ham8"}, 32'($countones(32'(bus8.gray) ^ pg8)), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus5.en       = 1'b0;
    bus5.up       = 1'b0;
    bus5.load     = 1'b0;
    bus5.load_val = '0;
    bus8.en       = 1'b0;
    bus8.up       = 1'b0;
    bus8.load     = 1'b0;
    bus8.load_val = '0;

    // Reset with load and enable both requested.
    bus5.load = 1'b1; bus5.load_val = 5'b10101; bus5.en = 1'b1;
    bus8.load = 1'b1; bus8.load_val = 8'hA5;
    @(negedge clk);
    cycle("reset");
    check("reset_bin5", 32'(bus5.bin), 32'h0);

    // Three increments from zero.
    rst_n = 1'b1;
    bus5.load = 1'b0; bus5.en = 1'b1; bus5.up = 1'b1;
    bus8.load = 1'b0;
    for (int i = 0; i < 3; i++) cycle("inc3");
    check("inc3_bin",  32'(bus5.bin),  32'b00011);
    check("inc3_gray", 32'(bus5.gray), 32'b00010);

    // Load all-ones, then wrap upward.
    bus5.load = 1'b1; bus5.load_val = 5'b11111; bus5.en = 1'b0;
    cycle("load_ones");
    check("load_ones_gray", 32'(bus5.gray), 32'b10000);
    bus5.load = 1'b0; bus5.en = 1'b1; bus5.up = 1'b1;
    cycle("wrap_up");
    check("wrap_up_wrap", 32'(bus5.wrap), 32'd1);
    bus5.en = 1'b0;
    cycle("wrap_up_hold");
    check("wrap_up_pulse_end", 32'(bus5.wrap), 32'd0);

    // Count down from zero through the wrap.
    bus5.en = 1'b1; bus5.up = 1'b0;
    cycle("wrap_dn");
    check("wrap_dn_gray", 32'(bus5.gray), 32'b10000);
    check("wrap_dn_wrap", 32'(bus5.wrap), 32'd1);
    cycle("dn_next");
    check("dn_next_gray", 32'(bus5.gray), 32'b10001);

    // Load beats enable; then one step up from the loaded value.
    bus5.load = 1'b1; bus5.load_val = 5'b10101; bus5.en = 1'b1; bus5.up = 1'b1;
    cycle("load_en");
    check("load_en_gray", 32'(bus5.gray), 32'b11111);
    bus5.load = 1'b0;
    cycle("after_load");
    check("after_load_gray", 32'(bus5.gray), 32'b11101);

    // Reloading the current all-ones value is not a step and raises no wrap.
    bus5.load = 1'b1; bus5.load_val = 5'b11111;
    cycle("reload_a");
    cycle("reload_same");
    check("reload_same_wrap", 32'(bus5.wrap), 32'd0);

    // Reset mid-count while loading.
    bus5.load_val = 5'b01100; bus5.en = 1'b0;
    cycle("load_12");
    bus5.en = 1'b1; bus5.load = 1'b1; bus5.load_val = 5'b00111; rst_n = 1'b0;
    cycle("mid_reset");
    check("mid_reset_bin", 32'(bus5.bin), 32'h0);
    rst_n = 1'b1; bus5.load = 1'b0;

    // Free run with random direction changes on both widths.
    bus5.en = 1'b1; bus8.en = 1'b1;
    for (int i = 0; i < 259; i++) begin
      bus5.up = 1'($urandom);
      bus8.up = 1'($urandom);
      cycle("freerun");
    end

    // Fully random control mix, with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rst_n         = ($urandom % 40) != 0;
      bus5.load     = ($urandom % 8) == 0;
      bus5.en       = 1'($urandom);
      bus5.up       = 1'($urandom);
      bus5.load_val = 5'($urandom);
      bus8.load     = ($urandom % 8) == 0;
      bus8.en       = 1'($urandom);
      bus8.up       = 1'($urandom);
      bus8.load_val = 8'($urandom);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter SIZE: default 8; counter width in bits, legal range 2..32.
REQ-002 clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 en  input  1  count enable; when high, advances the count by one step in the direction given by up.
REQ-005 up  input  1  direction; 1 = increment, 0 = decrement; ignored when en=0.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  SIZE  binary value loaded when load=1.
REQ-008 bin  output  SIZE  registered binary count.
REQ-009 gray  output  SIZE  registered Gray code of bin, i.e. bin XOR (bin >> 1).
REQ-010 wrap  output  1  registered one-cycle pulse; high in the cycle after the count wraps.

Function
REQ-011 Per-edge priority: rst_n=0, then load=1, then en=1, then hold.
REQ-012 load=1: bin <= load_val, gray <= Gray(load_val), wrap <= 0; en and up are ignored in that cycle.
REQ-013 en=1, up=1: bin <= bin+1, computed modulo 2^SIZE.
REQ-014 en=1, up=0: bin <= bin-1, computed modulo 2^SIZE.
REQ-015 en=0 and load=0: bin and gray hold their values; wrap <= 0.
REQ-016 gray is a register loaded from Gray(next bin) on the same edge as bin, so gray == Gray(bin) in every cycle, with no combinational path from any input to gray.
REQ-017 Latency: a stimulus sampled on edge N is visible on bin, gray and wrap after edge N.
REQ-018 wrap <= 1 exactly when en=1, load=0 and either (up=1 and bin = all-ones) or (up=0 and bin = 0); otherwise wrap <= 0.
REQ-019 Every enabled step, including wrap-around in either direction, changes exactly one bit of gray.
REQ-020 A direction change between consecutive enabled cycles is a legal single step; no dead cycle and no extra step.
REQ-021 load_val equal to the current bin still counts as a load: wrap <= 0 and there is no step.
REQ-022 bin, gray and wrap never take X after the first reset edge, given known inputs.

Reset
REQ-023 On a rising edge of clk with rst_n=0: bin <= 0, gray <= 0, wrap <= 0.
REQ-024 Reset overrides load and en in the same cycle, including reset asserted mid-count.
REQ-025 The first edge with rst_n=1 after reset applies the normal priority (REQ-011) starting from count 0.
REQ-026 No asynchronous reset path exists.

Structure
REQ-027 Shared package gray_pkg holds the default width constant GRAY_SIZE_DEFAULT = 8.
REQ-028 gray_pkg also holds a function bin_to_gray(value) for use by both RTL and bench.
REQ-029 Sub-module bin2gray (parameter SIZE): purely combinational, gray_o = bin_i ^ (bin_i >> 1).
REQ-030 gray_counter instantiates bin2gray once, on the next-state binary value, feeding the gray register.
REQ-031 Next-state logic is one combinational process; all state is held in a single clocked process.

Verification (SIZE=5 unless noted)
REQ-032 Reset then 3 cycles with en=1, up=1 -> bin 00011, gray 00010, wrap 0 throughout.
REQ-033 load=1, load_val=11111, then one cycle with en=1, up=1 -> first gray 10000; then bin 00000, gray 00000, wrap=1 for exactly one cycle.
REQ-034 Count down from 00000 with en=1, up=0 -> bin 11111, gray 10000, wrap=1; next step gives bin 11110, gray 10001, wrap 0.
REQ-035 load_val=10101 with load=1 and en=1 in the same cycle -> bin 10101, gray 11111, no step; then en=1, up=1 -> bin 10110, gray 11101.
REQ-036 Free-run 2^SIZE+3 enabled cycles, up randomly toggled, SIZE=5 and SIZE=8 -> every step has Hamming distance 1 on gray, and gray == bin_to_gray(bin) every cycle.
REQ-037 rst_n=0 asserted mid-count (bin=01100) together with load=1 -> next cycle bin 00000, gray 00000, wrap 0.
